// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single byte-wide write side of the fifo
// block among NREQ independent valid/ready producers. One producer at a time
// holds the grant for at most BURST accepted beats. The FIFO write strobe and
// data come combinationally from the granted producer, and FIFO `full` acts
// as backpressure: while it is high nothing is accepted and the grant is held.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   [NREQ]     per-requester data valid
//   req_data   in   [NREQ*DW]  packed data, requester i at [i*DW +: DW]
//   req_ready  out  [NREQ]     per-requester accept (only the granted bit)
//   full       in   FIFO full flag (must be a registered FIFO output)
//   wn         out  FIFO write enable
//   DATAIN     out  [DW]       FIFO write data (0 when no grant)
//   grant_id   out  index of the current or most recently granted requester
//   busy       out  a grant is active
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     full,
  output logic                     wn,
  output logic [DW-1:0]            DATAIN,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = 4;  // enough for BURST up to 15

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   grant_reg, grant_next;
  logic [IW-1:0]   last_reg,  last_next;
  logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;

  // Unpack the producer data bus so the granted lane can be picked by index.
  logic [DW-1:0]   data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan from last+1 upward, wrapping, first valid wins.
  // The requester that held the last grant is therefore checked last.
  // ---------------------------------------------------------------------------
  logic            rr_found;
  logic [IW-1:0]   rr_winner;

  always_comb begin
    logic [IW-1:0] cand;
    rr_found  = 1'b0;
    rr_winner = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_reg) + k) % NREQ);
      if (!rr_found && req_valid[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
    end
  end

  // Valid of the currently granted producer.
  logic cur_valid;
  assign cur_valid = req_valid[grant_reg];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      last_reg     <= IW'(NREQ - 1);  // requester 0 has top priority after reset
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      last_reg     <= last_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    last_next     = last_reg;
    beat_cnt_next = beat_cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (rr_found) begin
          state_next    = GRANT;
          grant_next    = rr_winner;
          last_next     = rr_winner;
          beat_cnt_next = '0;
        end
      end

      GRANT: begin
        if (!cur_valid) begin
          // Producer ended its burst early; nothing is written this cycle.
          state_next    = IDLE;
          beat_cnt_next = '0;
        end else if (!full) begin
          // A beat transfers on this edge.
          if (beat_cnt_reg == CW'(BURST - 1)) begin
            state_next    = IDLE;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
        // full with valid held: grant and count frozen, no timeout.
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Everything is derived from the state register and the live
  // inputs, so the asynchronous reset clears wn/busy/req_ready immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state_reg == GRANT);
    grant_id  = grant_reg;
    wn        = 1'b0;
    req_ready = '0;
    DATAIN    = '0;
    if (state_reg == GRANT) begin
      req_ready[grant_reg] = !full;
      wn                   = cur_valid & !full;
      DATAIN               = data_arr[grant_reg];
    end
  end

endmodule
